// File: rtl/branch_predictor.sv
// Direct-mapped, tagged table of 2-bit saturating counters. A combinational lookup serves fetch;
// execute-stage outcomes train the table and drive the branch/mispredict performance counters.
module branch_predictor #(
  parameter int PC_WIDTH     = 32,
  parameter int LOG2_ENTRIES = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] guess_pc,
  input  logic                guess_is_br,
  output logic                guess_taken,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                check_is_br,
  input  logic                check_taken,
  input  logic                check_correct,
  input  logic                cnt_clr,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);
  localparam int ENTRIES = 1 << LOG2_ENTRIES;
  localparam int TAG_W   = PC_WIDTH - LOG2_ENTRIES - 2;

  logic [ENTRIES-1:0]            w_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] w_tag;
  logic [ENTRIES-1:0][1:0]       w_ctr;

  logic [LOG2_ENTRIES-1:0] w_g_idx;
  logic [TAG_W-1:0]        w_g_tag;
  logic                    w_g_hit;
  logic [LOG2_ENTRIES-1:0] w_c_idx;
  logic [TAG_W-1:0]        w_c_tag;
  logic                    w_c_hit;
  logic [1:0]              w_c_ctr;
  logic [1:0]              w_ctr_next;
  logic                    w_unused_pc_bits;

  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  // Byte-offset bits of the PC carry no information for the table.
  assign w_unused_pc_bits = ^{guess_pc[1:0], check_pc[1:0]};

  assign w_g_idx     = guess_pc[LOG2_ENTRIES+1:2];
  assign w_g_tag     = guess_pc[PC_WIDTH-1:LOG2_ENTRIES+2];
  assign w_g_hit     = w_valid[w_g_idx] && (w_tag[w_g_idx] == w_g_tag);
  assign guess_taken = guess_is_br & w_g_hit & w_ctr[w_g_idx][1];

  assign w_c_idx = check_pc[LOG2_ENTRIES+1:2];
  assign w_c_tag = check_pc[PC_WIDTH-1:LOG2_ENTRIES+2];
  assign w_c_hit = w_valid[w_c_idx] && (w_tag[w_c_idx] == w_c_tag);
  assign w_c_ctr = w_ctr[w_c_idx];

  always_comb begin
    w_ctr_next = 2'b01;
    if (w_c_hit) begin
      if (check_taken) w_ctr_next = (w_c_ctr == 2'b11) ? 2'b11 : w_c_ctr + 2'b01;
      else             w_ctr_next = (w_c_ctr == 2'b00) ? 2'b00 : w_c_ctr - 2'b01;
    end else begin
      // Allocation seeds weakly in the direction just observed.
      w_ctr_next = check_taken ? 2'b10 : 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             r_valid;
      logic [TAG_W-1:0] r_tag;
      logic [1:0]       r_ctr;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_tag   <= '0;
          r_ctr   <= 2'b01;
        end else if (check_is_br && (w_c_idx == LOG2_ENTRIES'(gi))) begin
          r_valid <= 1'b1;
          r_tag   <= w_c_tag;
          r_ctr   <= w_ctr_next;
        end
      end

      assign w_valid[gi] = r_valid;
      assign w_tag[gi]   = r_tag;
      assign w_ctr[gi]   = r_ctr;
    end
  endgenerate

  // Clear wins over a coincident branch, so that branch is never counted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (check_is_br) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (!check_correct) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued when stimulus is driven and
// drained against the DUT outputs mid-cycle, before the edge that applies the update.
module tb_branch_predictor;
  logic        clk;
  logic        rst;
  logic [31:0] guess_pc;
  logic        guess_is_br;
  logic        guess_taken;
  logic [31:0] check_pc;
  logic        check_is_br;
  logic        check_taken;
  logic        check_correct;
  logic        cnt_clr;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 guess_taken, 1 branch_count, 2 mispredict_count
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(.PC_WIDTH(32), .LOG2_ENTRIES(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .guess_pc         (guess_pc),
    .guess_is_br      (guess_is_br),
    .guess_taken      (guess_taken),
    .check_pc         (check_pc),
    .check_is_br      (check_is_br),
    .check_taken      (check_taken),
    .check_correct    (check_correct),
    .cnt_clr          (cnt_clr),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic guess(input logic [31:0] pc, input logic exp_v, input string name);
    guess_pc    = pc;
    guess_is_br = 1'b1;
    push_exp(name, 0, {31'd0, exp_v});
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic correct);
    check_pc      = pc;
    check_is_br   = 1'b1;
    check_taken   = taken;
    check_correct = correct;
  endtask

  task automatic expect_counts(input logic [31:0] bc, input logic [31:0] mc, input string name);
    push_exp({name, "_bc"}, 1, bc);
    push_exp({name, "_mc"}, 2, mc);
  endtask

  // Compare all pending expectations at the falling edge, then take one rising edge.
  task automatic tick();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = {31'd0, guess_taken};
        1:       obs = branch_count;
        default: obs = mispredict_count;
      endcase
      checks++;
      $display("txn %0d %s observed=%0h expected=%0h", checks, e.name, obs, e.exp);
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.name, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
    guess_is_br = 1'b0;
    check_is_br = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; guess_pc = '0; guess_is_br = 1'b0; check_pc = '0;
    check_is_br = 1'b0; check_taken = 1'b0; check_correct = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    guess(32'h100, 1'b0, "reset_guess");
    expect_counts(32'd0, 32'd0, "reset_cnt");
    tick();

    // Training one entry through its counter states
    resolve(32'h100, 1'b1, 1'b1);
    guess(32'h100, 1'b0, "alloc_same_cycle");
    tick();
    guess(32'h100, 1'b1, "alloc_taken_visible");
    tick();
    resolve(32'h100, 1'b0, 1'b1);
    guess(32'h100, 1'b1, "nt1_pre_update");
    tick();
    resolve(32'h100, 1'b0, 1'b1);
    guess(32'h100, 1'b0, "nt2_ctr01");
    tick();
    guess(32'h100, 1'b0, "ctr00");
    tick();
    for (int i = 0; i < 5; i++) begin
      resolve(32'h100, 1'b1, 1'b1);
      guess(32'h100, (i >= 2), $sformatf("taken_run_%0d", i));
      tick();
    end
    resolve(32'h100, 1'b0, 1'b1);
    guess(32'h100, 1'b1, "sat11_pre_nt");
    tick();
    guess(32'h100, 1'b1, "ctr10_after_nt");
    tick();
    guess_pc = 32'h100;
    push_exp("not_a_branch", 0, 32'd0);
    tick();

    // Aliasing on the same index with a different tag
    guess(32'h180, 1'b0, "alias_tag_miss");
    tick();
    resolve(32'h180, 1'b0, 1'b1);
    guess(32'h100, 1'b1, "alias_pre_evict");
    tick();
    guess(32'h100, 1'b0, "evicted_miss");
    tick();
    guess(32'h180, 1'b0, "alias_ctr01");
    tick();

    // Same-cycle lookup and update, no bypass
    resolve(32'h200, 1'b0, 1'b1);
    tick();
    resolve(32'h200, 1'b1, 1'b1);
    guess(32'h200, 1'b0, "same_cycle_old");
    tick();
    guess(32'h200, 1'b1, "same_cycle_new");
    tick();
    resolve(32'h104, 1'b1, 1'b1);
    guess(32'h200, 1'b1, "other_idx_update");
    tick();
    guess(32'h104, 1'b1, "idx1_trained");
    tick();

    // Performance counters
    cnt_clr = 1'b1;
    tick();
    expect_counts(32'd0, 32'd0, "after_clr");
    tick();
    begin
      int mis = 0;
      for (int i = 0; i < 10; i++) begin
        resolve(32'h300 + 32'(i * 4), 1'b1, !(i == 2 || i == 5 || i == 7));
        expect_counts(32'(i), 32'(mis), $sformatf("cnt_step_%0d", i));
        tick();
        if (i == 2 || i == 5 || i == 7) mis++;
      end
    end
    expect_counts(32'd10, 32'd3, "cnt_final");
    tick();
    resolve(32'h340, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    expect_counts(32'd10, 32'd3, "clr_cycle");
    tick();
    expect_counts(32'd0, 32'd0, "clr_with_branch");
    tick();

    // Reset mid-stream with a concurrent update
    resolve(32'h100, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    resolve(32'h140, 1'b1, 1'b0);
    guess(32'h100, 1'b1, "pre_reset_hit");
    expect_counts(32'd1, 32'd1, "pre_reset");
    tick();
    rst = 1'b0;
    guess(32'h100, 1'b0, "post_reset_100");
    expect_counts(32'd0, 32'd0, "post_reset");
    tick();
    guess(32'h140, 1'b0, "post_reset_no_alloc");
    tick();
    guess(32'h200, 1'b0, "post_reset_200");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
